// File: rtl/wb_pkg.sv
// Shared types for the register-writeback arbiter: default widths, the buffered
// load entry and the per-cycle output-select encoding.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_BUF,
    SEL_MEM
  } wb_sel_t;

endpackage

// File: rtl/wb_buffer.sv
// In-order circular buffer of load writebacks with per-entry live bits,
// squash-by-address and a youngest-match search (built only with WB_LOOKUP_EN).
module wb_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  input  logic                       squash,
  input  logic [WB_ADDR_W-1:0]       squash_rd,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [WB_ADDR_W-1:0]       lookup_rs,
  output logic                       lookup_hit,
  output logic [WB_DATA_W-1:0]       lookup_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q;

  assign head  = entries[head_ptr];
  assign count = count_q;

  // Popped slots are marked dead so every slot outside the occupied range stays dead.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && entries[i].rd == squash_rd) begin
          entries[i].live <= 1'b0;
        end
      end
      if (pop) begin
        entries[head_ptr].live <= 1'b0;
        head_ptr               <= head_ptr + 1'b1;
      end
      if (push) begin
        entries[tail_ptr] <= push_entry;
        tail_ptr          <= tail_ptr + 1'b1;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef WB_LOOKUP_EN
  logic [PTR_W-1:0] scan_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    scan_idx    = head_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_ptr + PTR_W'(k);
      if (CNT_W'(k) < count_q && entries[scan_idx].live &&
          entries[scan_idx].rd == lookup_rs && lookup_rs != '0) begin
        lookup_hit  = 1'b1;
        lookup_data = entries[scan_idx].data;
      end
    end
  end
`else
  logic unused_lookup_rs;
  assign unused_lookup_rs = ^lookup_rs;
  assign lookup_hit       = 1'b0;
  assign lookup_data      = '0;
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load writebacks onto the single register-file write port.
// Define WB_LOOKUP_EN to build the forwarding lookup; otherwise it reads as 0.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              reg_write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] lookup_rs,
  output logic              lookup_hit,
  output logic [DATA_W-1:0] lookup_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]  buf_count;
  wb_entry_t         buf_head;
  wb_entry_t         push_entry;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;
  wb_sel_t           sel;
  logic              alu_issue;
  logic              mem_fire;
  logic              push;
  logic              pop;

  assign mem_ready  = (buf_count < CNT_W'(DEPTH));
  assign alu_issue  = alu_valid && alu_rd != '0;
  assign mem_fire   = mem_valid && mem_ready;
  assign push_entry = '{live: 1'b1, rd: mem_rd, data: mem_data};

  always_comb begin
    sel = SEL_NONE;
    if (alu_issue) begin
      sel = SEL_ALU;
    end else if (buf_count != '0) begin
      sel = SEL_BUF;
    end else if (mem_fire && mem_rd != '0) begin
      sel = SEL_MEM;
    end
  end

  // A same-cycle load to the ALU's destination is older, so it is simply dropped.
  assign pop  = (sel == SEL_BUF);
  assign push = mem_fire && mem_rd != '0 && sel != SEL_MEM &&
                !(alu_issue && mem_rd == alu_rd);

  wb_buffer #(
    .DEPTH(DEPTH)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash     (alu_issue),
    .squash_rd  (alu_rd),
    .head       (buf_head),
    .count      (buf_count),
    .lookup_rs  (lookup_rs),
    .lookup_hit (buf_hit),
    .lookup_data(buf_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_enable <= 1'b0;
      address          <= '0;
      write_data       <= '0;
    end else begin
      reg_write_enable <= 1'b0;
      case (sel)
        SEL_ALU: begin
          reg_write_enable <= 1'b1;
          address          <= alu_rd;
          write_data       <= alu_data;
        end
        SEL_BUF: begin
          reg_write_enable <= buf_head.live;
          if (buf_head.live) begin
            address    <= buf_head.rd;
            write_data <= buf_head.data;
          end
        end
        SEL_MEM: begin
          reg_write_enable <= 1'b1;
          address          <= mem_rd;
          write_data       <= mem_data;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_LOOKUP_EN
  // A live buffered match is always younger than the committing write, so it wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (buf_hit) begin
      lookup_hit  = 1'b1;
      lookup_data = buf_data;
    end else if (reg_write_enable && address == lookup_rs && lookup_rs != '0) begin
      lookup_hit  = 1'b1;
      lookup_data = write_data;
    end
  end
`else
  logic unused_buf_lookup;
  assign unused_buf_lookup = buf_hit ^ (^buf_data);
  assign lookup_hit        = 1'b0;
  assign lookup_data       = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scoreboard bench for writeback_arbiter; lookup expectations follow
// whether WB_LOOKUP_EN is defined for the build.
module tb_writeback_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        reg_write_enable;
  logic [4:0]  address;
  logic [31:0] write_data;
  logic [4:0]  lookup_rs;
  logic        lookup_hit;
  logic [31:0] lookup_data;

`ifdef WB_LOOKUP_EN
  localparam bit LOOKUP_ON = 1'b1;
`else
  localparam bit LOOKUP_ON = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared;
  int   n_mismatched;

  writeback_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_rd          (mem_rd),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .reg_write_enable(reg_write_enable),
    .address         (address),
    .write_data      (write_data),
    .lookup_rs       (lookup_rs),
    .lookup_hit      (lookup_hit),
    .lookup_data     (lookup_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      checkValue({e.tag, "_we"}, {31'b0, reg_write_enable}, {31'b0, e.we});
      if (e.we) begin
        checkValue({e.tag, "_addr"}, {27'b0, address}, {27'b0, e.addr});
        checkValue({e.tag, "_data"}, write_data, e.data);
      end
    end
  endtask

  // Drive one cycle of inputs, record the write expected after the edge, then check it.
  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                               input string tag);
    exp_t e;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    e.we   = ewe;
    e.addr = ea;
    e.data = ed;
    e.tag  = tag;
    exp_q.push_back(e);
    @(negedge clk);
    checkOutput();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic checkReady(input logic exp, input string tag);
    checkValue(tag, {31'b0, mem_ready}, {31'b0, exp});
  endtask

  task automatic checkLookup(input logic [4:0] rs, input logic exp_hit, input logic [31:0] exp_data,
                             input string tag);
    lookup_rs = rs;
    #1;
    checkValue({tag, "_hit"}, {31'b0, lookup_hit}, {31'b0, exp_hit});
    checkValue({tag, "_data"}, lookup_data, exp_data);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_rd    = '0;
    mem_data  = '0;
    lookup_rs = 5'd3;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    checkValue("rst_we", {31'b0, reg_write_enable}, 32'd0);
    checkValue("rst_addr", {27'b0, address}, 32'd0);
    checkValue("rst_data", write_data, 32'd0);
    checkReady(1'b1, "rst_ready");
    checkLookup(5'd3, 1'b0, 32'd0, "rst_lookup");

    $display("[TB] single sources");
    applyStimulus(1, 5'd3, 32'h11, 0, 5'd0, 32'h0, 1, 5'd3, 32'h11, "alu_alone");
    checkReady(1'b1, "load_ready_before");
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd4, 32'h22, 1, 5'd4, 32'h22, "load_alone");
    checkReady(1'b1, "load_ready_after");

    $display("[TB] collision");
    applyStimulus(1, 5'd5, 32'hA, 1, 5'd6, 32'hB, 1, 5'd5, 32'hA, "coll_alu");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd6, 32'hB, "coll_load");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "coll_idle");

    $display("[TB] buffer full");
    for (int i = 0; i < 6; i++) begin
      checkReady(i < 4, $sformatf("full_ready%0d", i));
      applyStimulus(1, 5'd1, 32'h100 + i, 1, 5'(10 + i), 32'h200 + i,
                    1, 5'd1, 32'h100 + i, $sformatf("full_alu%0d", i));
    end
    checkReady(1'b0, "full_ready_drain");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'(10 + i), 32'h200 + i,
                    $sformatf("full_drain%0d", i));
    end
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "full_idle");
    checkReady(1'b1, "full_ready_empty");

    $display("[TB] squash");
    applyStimulus(1, 5'd1, 32'h300, 1, 5'd7, 32'h1, 1, 5'd1, 32'h300, "sq_fill");
    applyStimulus(1, 5'd7, 32'h2, 0, 5'd0, 32'h0, 1, 5'd7, 32'h2, "sq_alu");
    checkLookup(5'd7, LOOKUP_ON, LOOKUP_ON ? 32'h2 : 32'h0, "sq_lookup");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "sq_deadpop");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "sq_idle");
    applyStimulus(1, 5'd9, 32'h33, 1, 5'd9, 32'h44, 1, 5'd9, 32'h33, "sq_same_cycle");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "sq_discarded");

    $display("[TB] register zero");
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 32'h55, 0, 5'd0, 32'h0, "x0_load");
    applyStimulus(1, 5'd0, 32'h66, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "x0_alu");
    applyStimulus(1, 5'd0, 32'h66, 1, 5'd12, 32'h77, 1, 5'd12, 32'h77, "x0_alu_load");

    $display("[TB] lookup");
    applyStimulus(1, 5'd1, 32'h400, 1, 5'd8, 32'h5, 1, 5'd1, 32'h400, "lk_fill0");
    applyStimulus(1, 5'd2, 32'h401, 1, 5'd8, 32'h6, 1, 5'd2, 32'h401, "lk_fill1");
    checkLookup(5'd8, LOOKUP_ON, LOOKUP_ON ? 32'h6 : 32'h0, "lk_youngest");
    checkLookup(5'd2, LOOKUP_ON, LOOKUP_ON ? 32'h401 : 32'h0, "lk_outreg");
    checkLookup(5'd0, 1'b0, 32'h0, "lk_zero");
    checkLookup(5'd13, 1'b0, 32'h0, "lk_miss");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd8, 32'h5, "lk_drain0");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd8, 32'h6, "lk_drain1");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "lk_idle");

    $display("[TB] reset mid-drain");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd1, 32'h500 + i, 1, 5'(20 + i), 32'h600 + i,
                    1, 5'd1, 32'h500 + i, $sformatf("rd_fill%0d", i));
    end
    checkReady(1'b1, "rd_ready_partial");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkValue("rd_we", {31'b0, reg_write_enable}, 32'd0);
    checkValue("rd_addr", {27'b0, address}, 32'd0);
    checkValue("rd_data", write_data, 32'd0);
    checkReady(1'b1, "rd_ready");
    checkLookup(5'd20, 1'b0, 32'h0, "rd_lookup");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, $sformatf("rd_idle%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges the two register-writeback sources of the pipeline, the single-cycle ALU result and the variable-latency load return, into the one write port of the 32×32 register file. ALU writes always win; load results that collide are held in a small in-order buffer and drained on idle ALU cycles. Buffered writes that a younger ALU write makes stale are squashed. An optional lookup port exposes not-yet-committed values to the operand-forwarding logic.

## Interface
- DEPTH, 4: load-writeback buffer entries (power of two, ≥2)
- DATA_W, 32: data width
- ADDR_W, 5: register address width

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- alu_valid  input  1  ALU result this cycle
- alu_rd  input  ADDR_W  ALU destination
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  load result offered
- mem_rd  input  ADDR_W  load destination
- mem_data  input  DATA_W  load data
- mem_ready  output  1  load result accepted when mem_valid && mem_ready
- reg_write_enable  output  1  register-file write strobe (registered)
- address  output  ADDR_W  register-file write address (registered)
- write_data  output  DATA_W  register-file write data (registered)
- lookup_rs  input  ADDR_W  forwarding query address
- lookup_hit  output  1  uncommitted value exists for lookup_rs
- lookup_data  output  DATA_W  youngest uncommitted value for lookup_rs

## Operation
- Program order: an ALU write is always younger than any buffered load write and younger than a load offered in the same cycle.
- rd == 0 from either source: consumed, never buffered, never written. mem_ready still applies.
- Per-cycle output select, priority order:
  1. alu_valid && alu_rd != 0 → issue ALU write.
  2. Else, if the buffer head is live → issue the head and pop it. If the head is dead → pop it with no write (reg_write_enable = 0 that cycle).
  3. Else, if the buffer is empty and a load handshake occurs → issue the load directly with no buffering.
- Accepted loads not issued by step 3 are enqueued at the tail as live entries.
- Squash: when an ALU write to R issues, every buffered entry with rd == R is marked dead. A load accepted in the same cycle with mem_rd == R is discarded.
- mem_ready = (count < DEPTH). It is combinational from registered count only. A pop and a push in the same full cycle are not allowed.
- Buffer pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Lookup: returns the youngest live value for lookup_rs, searching the output register first, then the buffer from tail to head. lookup_rs == 0 gives hit = 0. Lookup is combinational.

## Timing
- Reset values: reg_write_enable = 0, address = 0, write_data = 0, buffer empty, all entries dead, mem_ready = 1, lookup_hit = 0.
- Latency: a write selected in cycle N appears on address/write_data with reg_write_enable = 1 in cycle N+1. The register file commits at the end of N+1.
- A buffered load drains one entry per cycle in which alu_valid is 0 or alu_rd == 0.
- Reset asserted mid-drain: the buffer is flushed and no write is issued in the following cycle.

## Configuration
- WB_LOOKUP_EN defined: lookup logic is present as described above.
- WB_LOOKUP_EN undefined: lookup ports remain, lookup_hit is tied to 0 and lookup_data to 0, and no comparators are built.

## Structure
- Package wb_pkg holds DATA_W/ADDR_W defaults, an entry struct {live, rd, data}, and an output-select enum {SEL_NONE, SEL_ALU, SEL_BUF, SEL_MEM}.
- Sub-module wb_buffer contains the circular buffer with live bits, squash-by-address, and tail-to-head match search. Top-level select logic and the output register live in writeback_arbiter.

## Test plan
- ALU alone: alu_rd = 3, data 0x11 in cycle 0 → write x3 = 0x11 in cycle 1. Load alone with buffer empty: mem_rd = 4, data 0x22 → write x4 = 0x22 next cycle, mem_ready stays 1.
- Collision: ALU x5 = 0xA and load x6 = 0xB in the same cycle → x5 written in cycle 1, x6 written in cycle 2.
- Full: ALU busy for 6 cycles with loads offered every cycle → mem_ready falls after 4 accepts, and the 4 entries drain in order once ALU goes idle.
- Squash: buffer holds load x7 = 0x1, then ALU writes x7 = 0x2 → only x7 = 0x2 is written, and the dead entry pops with a write-enable-0 cycle.
- rd 0 and lookup: load x0 gives no write. With buffer {x8 = 0x5, x8 = 0x6} and lookup_rs = 8 → hit = 1, data = 0x6. With WB_LOOKUP_EN undefined → hit = 0.
- Reset with 3 entries buffered → no writes afterward, mem_ready = 1, all outputs 0.
